ldpc_ber_ctrl: RTL and testbench

- Parametrised LDPC bit-error-rate test controller. It collects quantised noise LLRs from LANES parallel generator/quantiser lanes into a double-buffered frame store and hands each full frame to the LDPC decoder core.
- It counts decoded frames, frame errors and bit errors. All-zero codewords are transmitted, so every 1 in the decoder output is a bit error.
- It runs a programmable number of frames or until aborted. The next frame fills while the current one decodes.
- It sits between the per-lane gng+quant instances and ldpc_core.

---
 rtl/ldpc_ber_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ldpc_ber_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_ber_ctrl.sv
// LDPC BER test controller: per-lane LLR fill buffers double-buffered
// against the decoder input register, plus frame / error accounting.

// One generator lane: LLR shift register, fill count and popcount of the
// matching slice of the decoder hard decisions.
module ldpc_ber_lane #(
    parameter int DATA_W   = 5,
    parameter int LANE_LEN = 18,
    parameter int CW       = $clog2(LANE_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       en,
    input  logic                       valid,
    input  logic [DATA_W-1:0]          llr,
    input  logic [LANE_LEN-1:0]        res,
    output logic [LANE_LEN*DATA_W-1:0] buf_q,
    output logic                       full,
    output logic [CW-1:0]              ones
);
    localparam int BW = LANE_LEN * DATA_W;

    logic [CW-1:0]        cnt;
    logic [BW+DATA_W-1:0] shifted;

    assign full    = (cnt == CW'(LANE_LEN));
    assign shifted = {buf_q, llr};

    // Shift in accepted samples; clear on run start, rewind count on load/abort
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            buf_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && valid && !full) begin
            buf_q <= shifted[BW-1:0];
            cnt   <= cnt + CW'(1);
        end
    end

    // Ones in this lane's slice of the latched decoder result
    always_comb begin
        ones = '0;
        for (int j = 0; j < LANE_LEN; j++) ones = ones + CW'(res[j]);
    end
endmodule

module ldpc_ber_ctrl #(
    parameter int DATA_W    = 5,
    parameter int LANES     = 128,
    parameter int LANE_LEN  = 18,
    parameter int CNT_W     = 16,
    parameter int BIT_CNT_W = 24,
    localparam int DIM      = LANES * LANE_LEN
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        frame_limit,
    input  logic [LANES-1:0]        lane_valid,
    input  logic [LANES*DATA_W-1:0] lane_llr,
    output logic [LANES-1:0]        lane_ce,
    output logic                    core_en,
    output logic                    core_rst,
    output logic [DIM*DATA_W-1:0]   core_llr,
    input  logic                    core_term,
    input  logic                    core_err,
    input  logic [DIM-1:0]          core_res,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]        frame_errs,
    output logic [BIT_CNT_W-1:0]    bit_errs,
    output logic                    busy,
    output logic                    done
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_ACCT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int OW = $clog2(LANE_LEN + 1);
    localparam int PW = $clog2(DIM + 1);
    localparam int SW = ((BIT_CNT_W > PW) ? BIT_CNT_W : PW) + 1;

    logic [2:0]                             state;
    logic                                   err_q;
    logic [DIM-1:0]                         res_q;
    logic [LANES-1:0][LANE_LEN*DATA_W-1:0]  lane_buf;
    logic [LANES-1:0][OW-1:0]               lane_ones;
    logic [LANES-1:0]                       lane_full;
    logic                                   clr, rewind;
    logic [SW-1:0]                          pop_sum, be_sum;
    logic [CNT_W-1:0]                       fc_nxt, fe_nxt;
    logic [BIT_CNT_W-1:0]                   be_nxt;

    assign busy    = (state == S_WAIT) || (state == S_LOAD) ||
                     (state == S_DECODE) || (state == S_ACCT);
    assign done    = (state == S_DONE);
    assign lane_ce = {LANES{busy}} & ~lane_full;
    // abort beats start, so a clear only happens from a non-busy state
    assign clr     = start && !abort && !busy;
    assign rewind  = (state == S_LOAD) || (abort && busy);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ldpc_ber_lane #(.DATA_W(DATA_W), .LANE_LEN(LANE_LEN), .CW(OW)) u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .clr   (clr),
            .load  (rewind),
            .en    (busy),
            .valid (lane_valid[g]),
            .llr   (lane_llr[g*DATA_W +: DATA_W]),
            .res   (res_q[g*LANE_LEN +: LANE_LEN]),
            .buf_q (lane_buf[g]),
            .full  (lane_full[g]),
            .ones  (lane_ones[g])
        );
    end

    // Saturating next values for the three counters
    always_comb begin
        pop_sum = '0;
        for (int i = 0; i < LANES; i++) pop_sum = pop_sum + SW'(lane_ones[i]);
        be_sum = SW'(bit_errs) + pop_sum;
        be_nxt = (be_sum > SW'({BIT_CNT_W{1'b1}})) ? '1 : be_sum[BIT_CNT_W-1:0];
        fc_nxt = (frame_cnt == '1) ? frame_cnt : frame_cnt + CNT_W'(1);
        fe_nxt = (err_q && frame_errs != '1) ? frame_errs + CNT_W'(1) : frame_errs;
    end

    // Decode-side FSM, decoder handshake and accounting
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            core_en    <= 1'b0;
            core_rst   <= 1'b0;
            core_llr   <= '0;
            err_q      <= 1'b0;
            res_q      <= '0;
            frame_cnt  <= '0;
            frame_errs <= '0;
            bit_errs   <= '0;
        end else if (abort && busy) begin
            state    <= S_IDLE;
            core_en  <= 1'b0;
            core_rst <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (clr) begin
                    frame_cnt  <= '0;
                    frame_errs <= '0;
                    bit_errs   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: if (&lane_full) state <= S_LOAD;
                S_LOAD: begin
                    core_llr <= lane_buf;
                    core_rst <= 1'b1;
                    core_en  <= 1'b1;
                    state    <= S_DECODE;
                end
                S_DECODE: begin
                    core_rst <= 1'b0;
                    if (core_term) begin
                        err_q   <= core_err;
                        res_q   <= core_res;
                        core_en <= 1'b0;
                        state   <= S_ACCT;
                    end
                end
                S_ACCT: begin
                    frame_cnt  <= fc_nxt;
                    frame_errs <= fe_nxt;
                    bit_errs   <= be_nxt;
                    state      <= (frame_limit != '0 && fc_nxt == frame_limit) ? S_DONE : S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_ber_ctrl.sv
// Directed bench for ldpc_ber_ctrl: 4 lanes x 3 samples, 2-bit frame counters.
module tb_ldpc_ber_ctrl;
    localparam int DW = 5, LN = 4, LL = 3, CW = 2, BW = 8, DIM = LN * LL;

    logic                clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CW-1:0]       frame_limit = '0;
    logic [LN-1:0]       lane_valid = '0;
    logic [LN*DW-1:0]    lane_llr = '0;
    logic [LN-1:0]       lane_ce;
    logic                core_en, core_rst, core_term = 1'b0, core_err = 1'b0;
    logic [DIM*DW-1:0]   core_llr;
    logic [DIM-1:0]      core_res = '0;
    logic [CW-1:0]       frame_cnt, frame_errs;
    logic [BW-1:0]       bit_errs;
    logic                busy, done;
    int                  n_chk = 0, n_pass = 0;

    ldpc_ber_ctrl #(.DATA_W(DW), .LANES(LN), .LANE_LEN(LL), .CNT_W(CW), .BIT_CNT_W(BW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .frame_limit(frame_limit),
        .lane_valid(lane_valid), .lane_llr(lane_llr), .lane_ce(lane_ce),
        .core_en(core_en), .core_rst(core_rst), .core_llr(core_llr),
        .core_term(core_term), .core_err(core_err), .core_res(core_res),
        .frame_cnt(frame_cnt), .frame_errs(frame_errs), .bit_errs(bit_errs),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // lane i, sample k carries base + 3i + k
    task automatic fill(input int base);
        for (int k = 0; k < LL; k++) begin
            lane_valid = '1;
            for (int i = 0; i < LN; i++) lane_llr[i*DW +: DW] = DW'(base + 3*i + k);
            tick();
        end
        lane_valid = '0;
    endtask

    task automatic wait_rst;
        for (int c = 0; c < 20 && !core_rst; c++) tick();
        chk("core_rst_seen", 64'(core_rst), 64'd1);
    endtask

    function automatic logic [DIM*DW-1:0] exp_frame(input int base);
        logic [DIM*DW-1:0] f;
        f = '0;
        for (int i = 0; i < LN; i++)
            for (int k = 0; k < LL; k++) f[i*LL*DW + (LL-1-k)*DW +: DW] = DW'(base + 3*i + k);
        return f;
    endfunction

    initial begin
        logic [4:0]        v;
        logic [DIM*DW-1:0] f2;

        // reset
        tick(); tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_core_en", 64'(core_en), 0);
        chk("rst_lane_ce", 64'(lane_ce), 0);
        chk("rst_core_llr", 64'(core_llr), 0);
        rstn = 1'b1;
        tick();

        // samples offered while idle must be dropped
        lane_valid = '1; lane_llr = '1;
        tick(); tick();
        lane_valid = '0;

        // fill and load, limit 1
        frame_limit = 2'd1;
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy", 64'(busy), 1);
        chk("t1_ce_start", 64'(lane_ce), 64'hF);
        lane_valid = '1;
        for (int k = 0; k < LL; k++) begin
            for (int i = 0; i < LN; i++) lane_llr[i*DW +: DW] = DW'(1 + 3*i + k);
            tick();
            if (k == 1) chk("t1_ce_2samp", 64'(lane_ce), 64'hF);
        end
        chk("t1_ce_full", 64'(lane_ce), 0);
        lane_llr = '1;  // extra samples on full lanes are dropped
        tick();
        lane_valid = '0;
        wait_rst();
        chk("t1_core_en", 64'(core_en), 1);
        chk("t1_core_llr", 64'(core_llr), 64'(exp_frame(1)));
        chk("t1_lane0", 64'(core_llr[LL*DW-1:0]), 64'({5'd1, 5'd2, 5'd3}));
        tick();
        chk("t1_rst_1cyc", 64'(core_rst), 0);
        chk("t1_en_hold", 64'(core_en), 1);
        core_term = 1'b1; tick(); core_term = 1'b0;
        chk("t1_en_drop", 64'(core_en), 0);
        tick();
        chk("t1_done", 64'(done), 1);
        chk("t1_busy_done", 64'(busy), 0);
        chk("t1_fcnt", 64'(frame_cnt), 1);
        chk("t1_ce_done", 64'(lane_ce), 0);

        // error accounting and double buffering, limit 2
        frame_limit = 2'd2;
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_clear", 64'(frame_cnt), 0);
        fill(0);
        wait_rst();
        for (int c = 0; c < 20; c++) begin
            v = 5'(10 + c);
            lane_valid = '1; lane_llr = {LN{v}};
            tick();
        end
        lane_valid = '0;
        chk("t2_buffered_ce", 64'(lane_ce), 0);
        chk("t2_still_dec", 64'(core_en), 1);
        core_term = 1'b1; core_err = 1'b1; core_res = 12'b0000_1011_0101;
        tick();
        core_term = 1'b0; core_err = 1'b0; core_res = '0;
        tick(); tick();
        chk("t2_gap_nolaod", 64'(core_rst), 0);
        chk("t2_acc_fcnt", 64'(frame_cnt), 1);
        chk("t2_acc_bits", 64'(bit_errs), 5);
        tick();
        chk("t2_gap_load", 64'(core_rst), 1);
        f2 = '0;
        for (int i = 0; i < LN; i++) f2[i*LL*DW +: LL*DW] = {5'd10, 5'd11, 5'd12};
        chk("t2_frame2_llr", 64'(core_llr), 64'(f2));
        core_term = 1'b1; tick(); core_term = 1'b0;
        tick();
        chk("t2_fcnt", 64'(frame_cnt), 2);
        chk("t2_ferr", 64'(frame_errs), 1);
        chk("t2_bits", 64'(bit_errs), 5);
        chk("t2_done", 64'(done), 1);
        chk("t2_busy", 64'(busy), 0);

        // saturation, unlimited run
        frame_limit = 2'd0;
        start = 1'b1; tick(); start = 1'b0;
        for (int f = 0; f < 5; f++) begin
            fill(0);
            wait_rst();
            core_term = 1'b1; core_err = 1'b1; core_res = 12'h001;
            tick();
            core_term = 1'b0; core_err = 1'b0; core_res = '0;
        end
        tick(); tick();
        chk("t3_fcnt_sat", 64'(frame_cnt), 3);
        chk("t3_ferr_sat", 64'(frame_errs), 3);
        chk("t3_bits", 64'(bit_errs), 5);
        chk("t3_running", 64'(busy), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t3_abort_idle", 64'(busy), 0);

        // abort during decode of frame 2
        start = 1'b1; tick(); start = 1'b0;
        fill(0);
        wait_rst();
        core_term = 1'b1; tick(); core_term = 1'b0;
        fill(0);
        wait_rst();
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("t4_busy", 64'(busy), 0);
        chk("t4_core_en", 64'(core_en), 0);
        chk("t4_fcnt_hold", 64'(frame_cnt), 1);
        chk("t4_done", 64'(done), 0);
        core_term = 1'b1; core_err = 1'b1; core_res = '1;
        tick();
        core_term = 1'b0; core_err = 1'b0; core_res = '0;
        tick();
        chk("t4_term_ignored", 64'(frame_cnt), 1);
        chk("t4_bits_hold", 64'(bit_errs), 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_restart_clr", 64'(frame_cnt), 0);
        chk("t4_restart_ce", 64'(lane_ce), 64'hF);

        // reset mid-fill
        lane_valid = '1; lane_llr = '1;
        tick();
        rstn = 1'b0; tick(); rstn = 1'b1; lane_valid = '0;
        chk("t5_busy", 64'(busy), 0);
        chk("t5_ce", 64'(lane_ce), 0);
        chk("t5_core_en", 64'(core_en), 0);
        chk("t5_core_rst", 64'(core_rst), 0);
        chk("t5_llr", 64'(core_llr), 0);
        chk("t5_done", 64'(done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
